vram_dma: RTL
=============

Name: vram_dma

Overview:
- Writer side of the GPU VRAM interface: copies a block of bytes from a CPU-side source memory into VRAM (PMF/OBM/other regions) via the same data/address/write_enable port the renderers consume.
- Drives writes only while `writable` is high, so transfers land in the blanking window without corrupting the frame being rendered.
- Pauses automatically when the window closes and resumes when it reopens.
- Sits between the CPU bus bridge (register-programmed start) and the VRAM write port of the foreground/background blocks.

Parameters:
SRC_ADDR_WIDTH, 16, width of source memory address.
LEN_WIDTH, 10, width of transfer length in bytes (max 2^LEN_WIDTH-1).
DST_ADDR_WIDTH, `VRAM_ADDR_WIDTH, width of VRAM address.

Ports:
clk  input  1  GPU pixel clock (12.5875 MHz), the only clock.
rst  input  1  active-low asynchronous reset.
start  input  1  one-cycle request; sampled only in IDLE.
abort  input  1  cancels the current transfer; has priority over everything else.
src_base  input  SRC_ADDR_WIDTH  first source byte address.
dst_base  input  DST_ADDR_WIDTH  first VRAM byte address.
length  input  LEN_WIDTH  byte count.
writable  input  1  VRAM write window from video timing.
busy  output  1  transfer in progress.
done  output  1  one-cycle pulse on normal completion.
src_rd  output  1  source read strobe.
src_addr  output  SRC_ADDR_WIDTH  source read address.
src_data  input  8  read data, valid exactly 1 cycle after src_rd.
vram_address  output  DST_ADDR_WIDTH  VRAM write address.
vram_data  output  8  VRAM write data.
vram_write_enable  output  1  VRAM write strobe; the VRAM samples it on posedge.

Behaviour:
- Reset (rst=0, async): state IDLE, FIFO and counters cleared; all outputs 0. Reset mid-transfer abandons it with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: busy=0. On start=1 && abort=0:
  - latch src_base, dst_base, length into src_ptr, dst_ptr, reads_left, writes_left.
  - length==0 goes to DONE; otherwise goes to RUN.
- RUN: busy=1.
  - Read issue: src_rd=1, src_addr=src_ptr when reads_left>0 && (fifo_count + inflight - pop) < 2. On issue, src_ptr+1 and reads_left-1.
  - Reads are not gated by `writable`, so the FIFO prefills.
  - Returning src_data is pushed into a 2-entry FIFO at the end of the cycle after src_rd.
  - Write: vram_write_enable = fifo_nonempty && writable && !abort. vram_data = FIFO head, vram_address = dst_ptr (combinational from registers). On write: pop, dst_ptr+1, writes_left-1.
  - writable low: no writes; FIFO holds up to 2 bytes; reads stall on credit. No byte is lost or duplicated.
  - When the last write occurs (writes_left 1→0), next state is DONE.
- DONE: one cycle, done=1, busy=0, then IDLE.
- Throughput with writable high: 1 byte/cycle.
- Latency: start in cycle 0 → src_rd in cycle 1 → first write in cycle 3 → last of N bytes in cycle N+2 → done in cycle N+3.
- Address wrap: src_ptr wraps mod 2^SRC_ADDR_WIDTH; dst_ptr wraps mod 2^DST_ADDR_WIDTH. No region checking; software owns destination legality.
- abort=1 in any state:
  - src_rd=0 and vram_write_enable=0 that cycle.
  - Next state IDLE; FIFO flushed; the in-flight read's return data is discarded; no done pulse.
- start while busy or in DONE: ignored. start and abort in the same cycle: abort wins.
- Invariants (assertions):
  - fifo_count ≤ 2, inflight ≤ 1.
  - vram_write_enable implies writable.
  - Total writes = length for any non-aborted transfer.

Decomposition:
- Shared GPU package holds:
  - state enum (IDLE/RUN/DONE);
  - VRAM region bases PMF_BASE=12'h000, OBM_BASE=12'h800 (for benches and software-mirror checks);
  - VRAM_ADDR_WIDTH.
- Sub-module vram_dma_fifo: 2-entry synchronous FIFO with push/pop/count, async active-low reset, flush input.
- Top contains the FSM, pointers, counters and credit logic.

Test Plan:
- OBM load: src memory bytes 0x10..0x13 at 0x0200, dst_base=0x800, length=4, writable=1 → writes in cycles 3–6 to 0x800..0x803 with data 0x10..0x13; done=1 in cycle 7; busy high cycles 1–6.
- Window gating: same as the OBM load but writable=0 in cycles 0–9 → exactly 2 src_rd then stall; first write in cycle 10; all 4 bytes correct and in order; no write while writable=0.
- Toggling window: length=16, writable alternating 1/0 each cycle → 16 writes, consecutive addresses, data matches source, no duplicates, done after the last write.
- Zero length: start with length=0 → no src_rd, no writes; done pulse 1 cycle after start.
- Wrap and restart: dst_base=0xFFE, length=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001. A start pulse mid-transfer is ignored and the transfer still writes exactly 4 bytes.
- Abort and reset: abort in cycle 4 of a length=8 transfer → no writes from cycle 4 on, no done, busy=0 in cycle 5, a new start works normally. rst low mid-transfer → all outputs 0 immediately (async).

Source files
------------

// File: rtl/vram_dma_pkg.sv
// vram_dma_pkg
// Shared GPU definitions used by the VRAM DMA writer and its sub-blocks.
//   VRAM_ADDR_WIDTH : width of a VRAM byte address
//   PMF_BASE/OBM_BASE : start addresses of the pattern and object memory regions
//   FIFO_DEPTH : bytes the DMA may hold between source read and VRAM write
//   dma_state_e : DMA controller states
package vram_dma_pkg;

  localparam int VRAM_ADDR_WIDTH = 12;

  localparam logic [VRAM_ADDR_WIDTH-1:0] PMF_BASE = 12'h000;
  localparam logic [VRAM_ADDR_WIDTH-1:0] OBM_BASE = 12'h800;

  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } dma_state_e;

endpackage

// File: rtl/vram_dma_fifo.sv
// vram_dma_fifo
// Two-entry byte FIFO buffering source data until the VRAM write window allows it out.
//   clk      : GPU pixel clock
//   rst      : asynchronous active-low reset, clears contents and count
//   flush_i  : drop everything held (abort)
//   push_i   : store push_data_i at the end of this cycle
//   pop_i    : retire the current head at the end of this cycle
//   head_o   : oldest byte held
//   count_o  : number of bytes held (0..2)
module vram_dma_fifo
  import vram_dma_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic [1:0] count_o
);

  logic [7:0] mem_q [FIFO_DEPTH];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       push_ok;
  logic       pop_ok;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  always_comb begin
    push_ok = push_i && ((count_q != 2'(FIFO_DEPTH)) || pop_i);
    pop_ok  = pop_i && (count_q != 2'd0);
  end

  // Storage, pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= 8'h00;
      mem_q[1] <= 8'h00;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push_ok) - 2'(pop_ok);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/vram_dma.sv
// vram_dma
// Copies a block of bytes from CPU-side source memory into VRAM, writing only while
// the video timing reports the write window open. Reads run ahead of the window into
// a two-byte FIFO so a reopened window is served at one byte per cycle.
//   clk/rst           : pixel clock, asynchronous active-low reset
//   start             : one-cycle request, honoured only when idle
//   abort             : cancels everything this cycle, no done pulse
//   src_base/dst_base : first source / VRAM byte address
//   length            : byte count (0 completes immediately)
//   writable          : VRAM write window
//   busy/done         : transfer in progress / one-cycle completion pulse
//   src_rd/src_addr   : source read strobe and address, data returns next cycle on src_data
//   vram_*            : VRAM write port
module vram_dma
  import vram_dma_pkg::*;
#(
  parameter int SRC_ADDR_WIDTH = 16,
  parameter int LEN_WIDTH      = 10,
  parameter int DST_ADDR_WIDTH = VRAM_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [SRC_ADDR_WIDTH-1:0] src_base,
  input  logic [DST_ADDR_WIDTH-1:0] dst_base,
  input  logic [LEN_WIDTH-1:0]      length,
  input  logic                      writable,
  output logic                      busy,
  output logic                      done,
  output logic                      src_rd,
  output logic [SRC_ADDR_WIDTH-1:0] src_addr,
  input  logic [7:0]                src_data,
  output logic [DST_ADDR_WIDTH-1:0] vram_address,
  output logic [7:0]                vram_data,
  output logic                      vram_write_enable
);

  dma_state_e                state_q, state_d;
  logic [SRC_ADDR_WIDTH-1:0] src_ptr_q, src_ptr_d;
  logic [DST_ADDR_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
  logic [LEN_WIDTH-1:0]      reads_left_q, reads_left_d;
  logic [LEN_WIDTH-1:0]      writes_left_q, writes_left_d;
  logic                      inflight_q, inflight_d;

  logic [1:0] fifo_count;
  logic [7:0] fifo_head;
  logic       fifo_push;
  logic       fifo_flush;
  logic       wr_fire;
  logic       rd_issue;
  logic [2:0] credit;

  vram_dma_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (fifo_flush),
    .push_i      (fifo_push),
    .push_data_i (src_data),
    .pop_i       (wr_fire),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  // Next-state, pointer and strobe logic. A read may issue only if the bytes
  // already held plus the one still returning, minus the one leaving now, leave
  // room in the FIFO; this keeps a stalled window from ever dropping a byte.
  always_comb begin
    state_d       = state_q;
    src_ptr_d     = src_ptr_q;
    dst_ptr_d     = dst_ptr_q;
    reads_left_d  = reads_left_q;
    writes_left_d = writes_left_q;
    wr_fire       = 1'b0;
    rd_issue      = 1'b0;
    fifo_flush    = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    credit        = 3'd0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          src_ptr_d     = src_base;
          dst_ptr_d     = dst_base;
          reads_left_d  = length;
          writes_left_d = length;
          state_d       = (length == '0) ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN: begin
        busy     = 1'b1;
        wr_fire  = (fifo_count != 2'd0) && writable && !abort;
        credit   = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, wr_fire};
        rd_issue = (reads_left_q != '0) && (credit < 3'(FIFO_DEPTH)) && !abort;
        if (rd_issue) begin
          src_ptr_d    = src_ptr_q + SRC_ADDR_WIDTH'(1);
          reads_left_d = reads_left_q - LEN_WIDTH'(1);
        end
        if (wr_fire) begin
          dst_ptr_d     = dst_ptr_q + DST_ADDR_WIDTH'(1);
          writes_left_d = writes_left_q - LEN_WIDTH'(1);
          if (writes_left_q == LEN_WIDTH'(1)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        done    = !abort;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d    = ST_IDLE;
      fifo_flush = 1'b1;
    end
  end

  // Data returning for a read issued last cycle is dropped if an abort arrives now.
  always_comb begin
    inflight_d = rd_issue;
    fifo_push  = inflight_q && !abort;
  end

  // Controller registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      src_ptr_q     <= '0;
      dst_ptr_q     <= '0;
      reads_left_q  <= '0;
      writes_left_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_ptr_q     <= src_ptr_d;
      dst_ptr_q     <= dst_ptr_d;
      reads_left_q  <= reads_left_d;
      writes_left_q <= writes_left_d;
      inflight_q    <= inflight_d;
    end
  end

  assign src_rd            = rd_issue;
  assign src_addr          = src_ptr_q;
  assign vram_address      = dst_ptr_q;
  assign vram_data         = fifo_head;
  assign vram_write_enable = wr_fire;

  // Structural invariants of the credit scheme and the write window.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (fifo_count <= 2'(FIFO_DEPTH));
      assert (!(vram_write_enable && !writable));
      assert ({1'b0, fifo_count} + {2'b00, inflight_q} <= 3'(FIFO_DEPTH));
    end
  end

endmodule
